// File: rtl/gpio_edge_irq_if.sv
// Register strobe bus between the GPIO wrapper (master) and gpio_edge_irq (slave).
//   reg_addr   word index of the register
//   reg_wr     one-cycle write strobe
//   reg_rd     read strobe
//   reg_wdata  write data
//   reg_rdata  registered read data, returned by the slave
interface gpio_edge_irq_if #(
    parameter int WIDTH = 32
);
    logic [2:0]       reg_addr;
    logic             reg_wr;
    logic             reg_rd;
    logic [WIDTH-1:0] reg_wdata;
    logic [WIDTH-1:0] reg_rdata;

    modport master (
        output reg_addr,
        output reg_wr,
        output reg_rd,
        output reg_wdata,
        input  reg_rdata
    );

    modport slave (
        input  reg_addr,
        input  reg_wr,
        input  reg_rd,
        input  reg_wdata,
        output reg_rdata
    );
endinterface

// File: rtl/gpio_edge_irq.sv
// GPIO input conditioner and interrupt source.
// Per pin: 2-FF synchroniser, optional tick-based debounce, rise/fall detection,
// sticky pending bits OR-reduced into one registered interrupt.
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   pin_in     raw pin levels, asynchronous to clk
//   bus        register strobe port (slave side)
//   level_out  conditioned pin level
//   irq        registered interrupt request
// Register map: 0 LEVEL(RO) 1 RISE_EN 2 FALL_EN 3 PENDING(W1C) 4 DEB_EN
//               5 PEND_SET(W1S, reads 0) 6-7 reserved (read 0)
module gpio_edge_irq #(
    parameter int WIDTH    = 32,
    parameter int TICK_DIV = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pin_in,
    gpio_edge_irq_if.slave   bus,
    output logic [WIDTH-1:0] level_out,
    output logic             irq
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

    logic [WIDTH-1:0] s1, s2;
    logic [WIDTH-1:0] hist0, hist1;
    logic [WIDTH-1:0] level, level_d, level_nxt;
    logic [WIDTH-1:0] rise_en, fall_en, deb_en, pending, pending_nxt;
    logic [WIDTH-1:0] rise, fall, w1c, w1s, agree, sel;
    logic [WIDTH-1:0] rd_mux;
    logic [CW-1:0]    cnt;
    logic             tick;

    assign tick      = (cnt == CNT_MAX);
    assign level_out = level;

    // A debounced bit follows s2 only when the two previous tick samples and
    // the current one all agree; an undebounced bit follows s2 every cycle.
    always_comb begin
        agree     = ~(hist1 ^ hist0) & ~(hist0 ^ s2);
        sel       = ~deb_en | (tick ? agree : '0);
        level_nxt = (s2 & sel) | (level & ~sel);
    end

    always_comb begin
        rise = level & ~level_d;
        fall = ~level & level_d;
        w1c  = (bus.reg_wr && bus.reg_addr == 3'd3) ? bus.reg_wdata : '0;
        w1s  = (bus.reg_wr && bus.reg_addr == 3'd5) ? bus.reg_wdata : '0;
        // Hardware/software set is applied after the clear so a new event
        // arriving with a W1C on the same bit is not lost.
        pending_nxt = (pending & ~w1c) | (rise & rise_en) | (fall & fall_en) | w1s;
    end

    always_comb begin
        rd_mux = '0;
        case (bus.reg_addr)
            3'd0:    rd_mux = level;
            3'd1:    rd_mux = rise_en;
            3'd2:    rd_mux = fall_en;
            3'd3:    rd_mux = pending;
            3'd4:    rd_mux = deb_en;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1            <= '0;
            s2            <= '0;
            hist0         <= '0;
            hist1         <= '0;
            level         <= '0;
            level_d       <= '0;
            rise_en       <= '0;
            fall_en       <= '0;
            deb_en        <= '0;
            pending       <= '0;
            cnt           <= '0;
            bus.reg_rdata <= '0;
            irq           <= 1'b0;
        end else begin
            s1      <= pin_in;
            s2      <= s1;
            cnt     <= tick ? '0 : cnt + CW'(1);
            if (tick) begin
                hist1 <= hist0;
                hist0 <= s2;
            end
            level   <= level_nxt;
            level_d <= level;
            pending <= pending_nxt;
            irq     <= |pending;
            if (bus.reg_wr) begin
                case (bus.reg_addr)
                    3'd1:    rise_en <= bus.reg_wdata;
                    3'd2:    fall_en <= bus.reg_wdata;
                    3'd4:    deb_en  <= bus.reg_wdata;
                    default: ;
                endcase
            end
            if (bus.reg_rd)
                bus.reg_rdata <= rd_mux;
        end
    end
endmodule

// File: tb/tb_gpio_edge_irq.sv
// Scoreboard bench for gpio_edge_irq (WIDTH=32, TICK_DIV=4).
module tb_gpio_edge_irq;
    localparam int K_RDATA = 0;
    localparam int K_LEVEL = 1;
    localparam int K_IRQ   = 2;

    typedef struct {
        int          due;
        int          kind;
        logic [31:0] exp;
        string       name;
    } chk_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pin_in;
    logic [31:0] level_out;
    logic        irq;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    chk_t        q[$];

    gpio_edge_irq_if #(.WIDTH(32)) bus ();

    gpio_edge_irq #(.WIDTH(32), .TICK_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .pin_in    (pin_in),
        .bus       (bus),
        .level_out (level_out),
        .irq       (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every queued expectation whose due cycle has come.
    always @(negedge clk) begin
        logic [31:0] act;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].due == cyc) begin
                case (q[i].kind)
                    K_RDATA: act = bus.reg_rdata;
                    K_LEVEL: act = level_out;
                    default: act = {31'b0, irq};
                endcase
                checks = checks + 1;
                if (act !== q[i].exp) begin
                    errors = errors + 1;
                    $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
                             q[i].name, act, q[i].exp, cyc);
                end
                q.delete(i);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks pending", q.size());
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input int kind, input logic [31:0] exp, input string name);
        chk_t c;
        c.due = cyc; c.kind = kind; c.exp = exp; c.name = name;
        q.push_back(c);
    endtask

    task automatic reg_write(input logic [2:0] addr, input logic [31:0] data);
        bus.reg_addr = addr; bus.reg_wdata = data; bus.reg_wr = 1'b1;
        tick();
        bus.reg_wr = 1'b0;
    endtask

    task automatic reg_read(input logic [2:0] addr, input logic [31:0] exp, input string name);
        chk_t c;
        bus.reg_addr = addr; bus.reg_rd = 1'b1;
        c.due = cyc + 1; c.kind = K_RDATA; c.exp = exp; c.name = name;
        q.push_back(c);
        tick();
        bus.reg_rd = 1'b0;
    endtask

    task automatic reg_rdwr(input logic [2:0] addr, input logic [31:0] data,
                            input logic [31:0] exp, input string name);
        chk_t c;
        bus.reg_addr = addr; bus.reg_wdata = data; bus.reg_rd = 1'b1; bus.reg_wr = 1'b1;
        c.due = cyc + 1; c.kind = K_RDATA; c.exp = exp; c.name = name;
        q.push_back(c);
        tick();
        bus.reg_rd = 1'b0; bus.reg_wr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pin_in = 32'hFFFF_FFFF;
        bus.reg_addr = 3'd0; bus.reg_wr = 1'b0; bus.reg_rd = 1'b0; bus.reg_wdata = '0;

        // 1 reset
        tick(); tick();
        expect_now(K_LEVEL, 32'h0, "rst_level");
        expect_now(K_IRQ,   32'h0, "rst_irq");
        expect_now(K_RDATA, 32'h0, "rst_rdata");
        checks = checks + 1;
        if (level_out !== 32'h0) begin
            errors = errors + 1;
            $display("FAIL d_rst_level: got 0x%08h", level_out);
        end
        rst = 1'b0;
        tick(); tick();
        expect_now(K_LEVEL, 32'h0, "release_level_early");
        tick();
        expect_now(K_LEVEL, 32'hFFFF_FFFF, "release_level");
        expect_now(K_IRQ,   32'h0, "release_irq");
        checks = checks + 1;
        if (level_out !== 32'hFFFF_FFFF) begin
            errors = errors + 1;
            $display("FAIL d_release_level: got 0x%08h", level_out);
        end
        pin_in = 32'h0;
        repeat (4) tick();
        expect_now(K_LEVEL, 32'h0, "pins_low");

        // 2 rise without debounce
        reg_write(3'd1, 32'h1);
        pin_in = 32'h1;
        tick(); tick();
        expect_now(K_LEVEL, 32'h0, "rise_level_n1");
        tick();
        expect_now(K_LEVEL, 32'h1, "rise_level_n2");
        expect_now(K_IRQ,   32'h0, "rise_irq_n2");
        checks = checks + 1;
        if (level_out !== 32'h1) begin
            errors = errors + 1;
            $display("FAIL d_rise_level: got 0x%08h", level_out);
        end
        tick();
        expect_now(K_IRQ,   32'h0, "rise_irq_n3");
        reg_read(3'd3, 32'h1, "rise_pending");
        expect_now(K_IRQ,   32'h1, "rise_irq_n4");
        reg_write(3'd3, 32'h1);
        expect_now(K_IRQ,   32'h1, "w1c_irq_lag");
        tick();
        expect_now(K_IRQ,   32'h0, "w1c_irq_clear");
        checks = checks + 1;
        if (irq !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL d_w1c_irq: got %b", irq);
        end

        // 3 debounce
        pin_in = 32'h3;
        repeat (4) tick();
        expect_now(K_LEVEL, 32'h3, "deb_settle");
        reg_write(3'd4, 32'h2);
        reg_write(3'd2, 32'h2);
        repeat (8) tick();
        pin_in = 32'h1;
        repeat (3) tick();
        pin_in = 32'h3;
        repeat (12) tick();
        expect_now(K_LEVEL, 32'h3, "glitch_level");
        expect_now(K_IRQ,   32'h0, "glitch_irq");
        reg_read(3'd3, 32'h0, "glitch_pending");
        pin_in = 32'h1;
        repeat (8) tick();
        expect_now(K_LEVEL, 32'h3, "deb_hold_early");
        repeat (8) tick();
        expect_now(K_LEVEL, 32'h1, "deb_fall_level");
        checks = checks + 1;
        if (level_out !== 32'h1) begin
            errors = errors + 1;
            $display("FAIL d_deb_fall_level: got 0x%08h", level_out);
        end
        reg_read(3'd3, 32'h2, "deb_fall_pending");
        expect_now(K_IRQ,   32'h1, "deb_fall_irq");
        reg_write(3'd3, 32'h2);
        tick();
        expect_now(K_IRQ,   32'h0, "deb_clear_irq");

        // 4 W1C colliding with a new rise on the same bit
        pin_in = 32'h0;
        repeat (4) tick();
        expect_now(K_LEVEL, 32'h0, "coll_low");
        reg_write(3'd5, 32'h1);
        tick();
        expect_now(K_IRQ,   32'h1, "coll_pre_irq");
        pin_in = 32'h1;
        tick(); tick(); tick();
        reg_write(3'd3, 32'h1);
        expect_now(K_IRQ,   32'h1, "coll_irq_a");
        reg_read(3'd3, 32'h1, "coll_pending");
        expect_now(K_IRQ,   32'h1, "coll_irq_b");
        reg_write(3'd3, 32'h1);
        reg_read(3'd3, 32'h0, "coll_cleared");

        // 5 software set and decode
        reg_write(3'd5, 32'hA);
        tick();
        expect_now(K_IRQ, 32'h1, "w1s_irq");
        reg_read(3'd5, 32'h0, "rd_pend_set");
        reg_read(3'd7, 32'h0, "rd_addr7");
        reg_read(3'd3, 32'hA, "rd_pending");
        reg_read(3'd0, 32'h1, "rd_level");
        reg_read(3'd1, 32'h1, "rd_rise_en");
        reg_read(3'd2, 32'h2, "rd_fall_en");
        reg_read(3'd4, 32'h2, "rd_deb_en");
        reg_write(3'd6, 32'hFFFF_FFFF);
        reg_read(3'd6, 32'h0, "rd_addr6");
        reg_rdwr(3'd3, 32'hA, 32'hA, "rdwr_prewrite");
        reg_read(3'd3, 32'h0, "rdwr_after");
        expect_now(K_IRQ, 32'h0, "rdwr_irq");

        // 6 reset in the middle of a debounce
        pin_in = 32'h3;
        reg_write(3'd5, 32'h4);
        repeat (5) tick();
        expect_now(K_IRQ, 32'h1, "pre_rst_irq");
        rst = 1'b1;
        tick(); tick();
        expect_now(K_LEVEL, 32'h0, "mid_rst_level");
        expect_now(K_IRQ,   32'h0, "mid_rst_irq");
        expect_now(K_RDATA, 32'h0, "mid_rst_rdata");
        rst = 1'b0;
        reg_write(3'd4, 32'h2);
        tick(); tick();
        expect_now(K_LEVEL, 32'h1, "post_rst_r3");
        repeat (8) tick();
        expect_now(K_LEVEL, 32'h1, "post_rst_r11");
        tick();
        expect_now(K_LEVEL, 32'h3, "post_rst_r12");
        checks = checks + 1;
        if (level_out !== 32'h3) begin
            errors = errors + 1;
            $display("FAIL d_post_rst_level: got 0x%08h", level_out);
        end
        reg_read(3'd3, 32'h0, "post_rst_pending");
        expect_now(K_IRQ, 32'h0, "post_rst_irq");

        repeat (3) tick();
        while (q.size() > 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s: never compared, expected 0x%08h", q[0].name, q[0].exp);
            void'(q.pop_front());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
